// File: rtl/rf_arb_pkg.sv
// Shared constants and helpers for the register-file port arbiter.
package rf_arb_pkg;

  localparam int unsigned RF_ADDR_W   = 4;
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 16;
  localparam int unsigned MAX_REQ     = 8;

  // OR-encode a one-hot vector; an all-zero vector maps to index 0.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the rotating pointer.
module rr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            adv,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] scan_idx;
  logic            found;

  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = IdxW'((32'(ptr_q) + k) % N);
      if (!found && req[scan_idx]) begin
        gnt[scan_idx] = 1'b1;
        found         = 1'b1;
      end
    end
    gnt_idx = IdxW'(onehot_to_idx(MAX_REQ'(gnt)));
  end

  // Pointer moves just past the winner; it holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (adv && found) begin
      ptr_q <= (gnt_idx == IdxW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares one RF write port and one RF read port among NUM_REQ requesters.
// Optional macro RF_ARB_BYPASS_EN forwards same-cycle write data to a colliding read.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = RF_ADDR_W,
  parameter int unsigned DATA_W  = RF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rf_wr_en,
  output logic [ADDR_W-1:0]         rf_wr_addr,
  output logic [DATA_W-1:0]         rf_wr_data,
  output logic [ADDR_W-1:0]         rf_rd_addr,
  input  logic [DATA_W-1:0]         rf_rd_data
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] wr_req, rd_req;
  logic [NUM_REQ-1:0] wr_gnt_raw, rd_gnt_raw;
  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [IdxW-1:0]    wr_idx, rd_idx;
  logic               rd_any;
  logic [DATA_W-1:0]  rd_capture;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;

  assign wr_req = req_valid & req_we;
  assign rd_req = req_valid & ~req_we;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .adv     (~rst),
    .gnt     (wr_gnt_raw),
    .gnt_idx (wr_idx)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req),
    .adv     (~rst),
    .gnt     (rd_gnt_raw),
    .gnt_idx (rd_idx)
  );

  // Grants are suppressed while reset is high so no RF access escapes.
  assign wr_gnt    = rst ? '0 : wr_gnt_raw;
  assign rd_gnt    = rst ? '0 : rd_gnt_raw;
  assign req_ready = wr_gnt | rd_gnt;
  assign rf_wr_en  = |wr_gnt;
  assign rd_any    = |rd_gnt;

  always_comb begin
    rf_wr_addr = '0;
    rf_wr_data = '0;
    rf_rd_addr = '0;
    if (rf_wr_en) begin
      rf_wr_addr = req_addr[32'(wr_idx) * ADDR_W +: ADDR_W];
      rf_wr_data = req_wdata[32'(wr_idx) * DATA_W +: DATA_W];
    end
    if (rd_any) begin
      rf_rd_addr = req_addr[32'(rd_idx) * ADDR_W +: ADDR_W];
    end
  end

`ifdef RF_ARB_BYPASS_EN
  assign rd_capture = (rf_wr_en && rd_any && (rf_wr_addr == rf_rd_addr)) ? rf_wr_data
                                                                          : rf_rd_data;
`else
  assign rd_capture = rf_rd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_gnt;
      if (rd_any) rsp_data_q <= rd_capture;
    end
  end

  // A response pending across a reset assertion is dropped, not delivered.
  assign rsp_valid = rsp_valid_q & {NUM_REQ{~rst}};
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Randomized scoreboard bench for rf_port_arbiter with a spec-level reference model.
module tb_rf_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, rf_wr_data, rf_rd_data;
  logic            rf_wr_en;
  logic [AW-1:0]   rf_wr_addr, rf_rd_addr;

  always #5 clk = ~clk;

  rf_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data)
  );

  // Register file driven by the DUT's ports.
  logic [DW-1:0] rf_mem [16] = '{default: '0};
  assign rf_rd_data = rf_mem[rf_rd_addr];
  always @(posedge clk) if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model state.
  int            m_wr_ptr = 0;
  int            m_rd_ptr = 0;
  logic [DW-1:0] m_mem [16] = '{default: '0};
  logic [AW-1:0] a_arr [N];
  logic [DW-1:0] d_arr [N];

  typedef struct {
    int            due;
    logic [N-1:0]  oh;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sb[$];
  bit   mon_en = 1'b0;

  function automatic int pick(input logic [N-1:0] cls, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (cls[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] we, input logic r);
    int            wi, ri;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] rd_val;
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_we    = we;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = a_arr[i];
      req_wdata[i*DW +: DW] = d_arr[i];
    end
    #1;
    if (r) begin
      chk("rst_ready", req_ready, '0);
      chk("rst_wr_en", rf_wr_en, 0);
      chk("rst_wr_addr", rf_wr_addr, 0);
      chk("rst_wr_data", rf_wr_data, 0);
      chk("rst_rd_addr", rf_rd_addr, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      while (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());
      m_wr_ptr = 0;
      m_rd_ptr = 0;
    end else begin
      wi = pick(v & we, m_wr_ptr);
      ri = pick(v & ~we, m_rd_ptr);
      exp_rdy = '0;
      if (wi >= 0) exp_rdy[wi] = 1'b1;
      if (ri >= 0) exp_rdy[ri] = 1'b1;
      chk("ready", req_ready, exp_rdy);
      chk("wr_en", rf_wr_en, wi >= 0);
      chk("wr_addr", rf_wr_addr, (wi >= 0) ? a_arr[wi] : '0);
      chk("wr_data", rf_wr_data, (wi >= 0) ? d_arr[wi] : '0);
      chk("rd_addr", rf_rd_addr, (ri >= 0) ? a_arr[ri] : '0);
      if (ri >= 0) begin
        rd_val = m_mem[a_arr[ri]];
`ifdef RF_ARB_BYPASS_EN
        if (wi >= 0 && a_arr[wi] == a_arr[ri]) rd_val = d_arr[wi];
`endif
        sb.push_back('{due: cyc + 1, oh: N'(1) << ri, data: rd_val});
        m_rd_ptr = (ri + 1) % N;
      end
      if (wi >= 0) begin
        m_mem[a_arr[wi]] = d_arr[wi];
        m_wr_ptr = (wi + 1) % N;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid !== '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, '0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_valid", rsp_valid, e.oh);
          chk("rsp_data", rsp_data, e.data);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("rsp_missing", rsp_valid, sb[0].oh);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      d_arr[i] = '0;
    end
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    mon_en = 1'b1;
    step('0, '0, 1'b0);
    chk("rst_rsp_data", rsp_data, 0);

    // Write fairness from a fresh pointer.
    for (int i = 0; i < N; i++) begin
      a_arr[i] = AW'(i + 1);
      d_arr[i] = 32'h100 + i;
    end
    for (int k = 0; k < 5; k++) begin
      step('1, '1, 1'b0);
      chk("fair_gnt", req_ready, N'(1) << (k % N));
      chk("fair_wr_en", rf_wr_en, 1);
    end

    // Single write then read of the same address.
    a_arr[1] = 4'd5; d_arr[1] = 32'hDEADBEEF;
    step(4'b0010, 4'b0010, 1'b0);
    a_arr[2] = 4'd5;
    step(4'b0100, 4'b0000, 1'b0);
    step('0, '0, 1'b0);
    chk("wr_rd_valid", rsp_valid, 4'b0100);
    chk("wr_rd_data", rsp_data, 32'hDEADBEEF);

    // Concurrent write and read classes.
    a_arr[0] = 4'd3; d_arr[0] = 32'hCAFE0003; a_arr[3] = 4'd7;
    step(4'b1001, 4'b0001, 1'b0);
    chk("conc_ready", req_ready, 4'b1001);
    chk("conc_wr_addr", rf_wr_addr, 3);
    chk("conc_rd_addr", rf_rd_addr, 7);
    step('0, '0, 1'b0);
    chk("conc_rsp", rsp_valid, 4'b1000);

    // Same-address collision on a never-written register.
    a_arr[0] = 4'd9; d_arr[0] = 32'h1; a_arr[1] = 4'd9;
    step(4'b0011, 4'b0001, 1'b0);
    step('0, '0, 1'b0);
`ifdef RF_ARB_BYPASS_EN
    chk("collide_data", rsp_data, 32'h1);
`else
    chk("collide_data", rsp_data, 32'h0);
`endif

    // Reset while a read response is in flight.
    a_arr[2] = 4'd5;
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 1'b1);
    step('0, '0, 1'b0);
    chk("rst_mid_rsp", rsp_valid, 0);

    // Read pointer holds across idle cycles.
    step(4'b0100, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) step('0, '0, 1'b0);
    a_arr[1] = 4'd3; a_arr[3] = 4'd7;
    step(4'b1010, 4'b0000, 1'b0);
    chk("hold_first", req_ready, 4'b1000);
    step(4'b0010, 4'b0000, 1'b0);
    chk("hold_second", req_ready, 4'b0010);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] v, we;
      for (int i = 0; i < N; i++) begin
        v[i]     = ($urandom_range(0, 9) < 6);
        we[i]    = $urandom_range(0, 1);
        a_arr[i] = AW'($urandom_range(0, 15));
        d_arr[i] = $urandom;
      end
      step(v, we, $urandom_range(0, 49) == 0);
    end
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
